// File: rtl/regfile_pkg.sv
// Shared constants and word type for the multiport register file.
// No logic lives here: default geometry and the zero-entry address only.
// No flow control: purely declarative.
package regfile_pkg;
  localparam int REGFILE_WIDTH     = 32;
  localparam int REGFILE_DEPTH     = 32;
  localparam int REGFILE_ZERO_ADDR = 0;

  typedef logic [REGFILE_WIDTH-1:0] regfile_word_t;
endpackage

// File: rtl/regfile_write_select.sv
// Reduces NWRITE {wen,waddr,wdata} lanes to one {hit,d} for a given address.
// Latency: purely combinational, zero cycles.
// No backpressure: highest-index matching lane wins, the others are dropped.
module regfile_write_select #(
  parameter int NWRITE = 1,
  parameter int WIDTH  = 32,
  parameter int AW     = 5
) (
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE-1:0][AW-1:0]    waddr,
  input  logic [NWRITE-1:0][WIDTH-1:0] wdata,
  input  logic [AW-1:0]                sel_addr,
  output logic                         hit,
  output logic [WIDTH-1:0]             d
);

  // Ascending scan so a later (higher-index) lane overrides earlier matches.
  always_comb begin
    hit = 1'b0;
    d   = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (waddr[j] == sel_addr)) begin
        hit = 1'b1;
        d   = wdata[j];
      end
    end
  end

endmodule

// File: rtl/regfile_zero_multiport.sv
// NREAD x NWRITE register file with optional hard-wired zero entry; macro REGFILE_BYPASS_EN
// enables same-cycle write-through. Reads combinational, writes land on the clk edge.
// No backpressure: every write is accepted; conflicts resolve to the highest port index.
module regfile_zero_multiport
  import regfile_pkg::*;
#(
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE-1:0][AW-1:0]    waddr,
  input  logic [NWRITE-1:0][WIDTH-1:0] wdata,
  input  logic [NREAD-1:0][AW-1:0]     raddr,
  output logic [NREAD-1:0][WIDTH-1:0]  rdata
);

  // Full power-of-two address space; slots past DEPTH and the zero entry are
  // constant 0 so the read mux needs no range check.
  localparam int NENT = 1 << AW;

  logic [NENT-1:0][WIDTH-1:0] mem;

  genvar e, i;

  for (e = 0; e < NENT; e++) begin : g_entry
    if ((e >= DEPTH) || ((ZERO_REG != 0) && (e == REGFILE_ZERO_ADDR))) begin : g_const
      assign mem[e] = '0;
    end else begin : g_store
      logic             we;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;

      regfile_write_select #(
        .NWRITE (NWRITE),
        .WIDTH  (WIDTH),
        .AW     (AW)
      ) u_sel (
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .sel_addr (AW'(e)),
        .hit      (we),
        .d        (d)
      );

      // Entry storage: cleared asynchronously, reset also blocks writes.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q <= '0;
        end else if (we) begin
          q <= d;
        end
      end

      assign mem[e] = q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Addresses whose writes actually land; bypass must ignore the rest.
  logic [NENT-1:0] writable;
  for (e = 0; e < NENT; e++) begin : g_writable
    assign writable[e] = !((e >= DEPTH) || ((ZERO_REG != 0) && (e == REGFILE_ZERO_ADDR)));
  end
`endif

  for (i = 0; i < NREAD; i++) begin : g_read
    logic [WIDTH-1:0] stored;
    assign stored = mem[raddr[i]];
`ifdef REGFILE_BYPASS_EN
    logic             byp_hit;
    logic [WIDTH-1:0] byp_d;

    regfile_write_select #(
      .NWRITE (NWRITE),
      .WIDTH  (WIDTH),
      .AW     (AW)
    ) u_byp (
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .sel_addr (raddr[i]),
      .hit      (byp_hit),
      .d        (byp_d)
    );

    // Write-through only when the write would really happen this edge.
    assign rdata[i] = (reset_n && byp_hit && writable[raddr[i]]) ? byp_d : stored;
`else
    assign rdata[i] = stored;
`endif
  end

endmodule

// File: tb/tb_regfile_zero_multiport.sv
// Directed and randomized checks of three register file configurations.
// u0: 2R/2W depth 32 zero entry; u1: 3R/2W depth 24 no zero entry; u2: 2R/1W depth 32.
// Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
module tb_regfile_zero_multiport;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int ND = 3;
  localparam int NR  [ND] = '{2, 3, 2};
  localparam int NW  [ND] = '{2, 2, 1};
  localparam int DEP [ND] = '{32, 24, 32};
  localparam int ZR  [ND] = '{1, 0, 1};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          wen_a   [ND][2];
  logic [4:0]    waddr_a [ND][2];
  regfile_word_t wdata_a [ND][2];
  logic [4:0]    raddr_a [ND][3];
  regfile_word_t rd_a    [ND][3];
  regfile_word_t mdl     [ND][32];

  int checks = 0;
  int failures = 0;

  logic [1:0]       u0_wen;
  logic [1:0][4:0]  u0_waddr;
  logic [1:0][31:0] u0_wdata;
  logic [1:0][4:0]  u0_raddr;
  logic [1:0][31:0] u0_rdata;
  logic [1:0]       u1_wen;
  logic [1:0][4:0]  u1_waddr;
  logic [1:0][31:0] u1_wdata;
  logic [2:0][4:0]  u1_raddr;
  logic [2:0][31:0] u1_rdata;
  logic [0:0]       u2_wen;
  logic [0:0][4:0]  u2_waddr;
  logic [0:0][31:0] u2_wdata;
  logic [1:0][4:0]  u2_raddr;
  logic [1:0][31:0] u2_rdata;

  assign u0_wen   = {wen_a[0][1], wen_a[0][0]};
  assign u0_waddr = {waddr_a[0][1], waddr_a[0][0]};
  assign u0_wdata = {wdata_a[0][1], wdata_a[0][0]};
  assign u0_raddr = {raddr_a[0][1], raddr_a[0][0]};
  assign u1_wen   = {wen_a[1][1], wen_a[1][0]};
  assign u1_waddr = {waddr_a[1][1], waddr_a[1][0]};
  assign u1_wdata = {wdata_a[1][1], wdata_a[1][0]};
  assign u1_raddr = {raddr_a[1][2], raddr_a[1][1], raddr_a[1][0]};
  assign u2_wen   = wen_a[2][0];
  assign u2_waddr = waddr_a[2][0];
  assign u2_wdata = wdata_a[2][0];
  assign u2_raddr = {raddr_a[2][1], raddr_a[2][0]};

  assign rd_a[0][0] = u0_rdata[0];
  assign rd_a[0][1] = u0_rdata[1];
  assign rd_a[0][2] = '0;
  assign rd_a[1][0] = u1_rdata[0];
  assign rd_a[1][1] = u1_rdata[1];
  assign rd_a[1][2] = u1_rdata[2];
  assign rd_a[2][0] = u2_rdata[0];
  assign rd_a[2][1] = u2_rdata[1];
  assign rd_a[2][2] = '0;

  regfile_zero_multiport #(.NREAD(2), .NWRITE(2), .WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u0 (
    .clk(clk), .reset_n(reset_n), .wen(u0_wen), .waddr(u0_waddr), .wdata(u0_wdata),
    .raddr(u0_raddr), .rdata(u0_rdata));

  regfile_zero_multiport #(.NREAD(3), .NWRITE(2), .WIDTH(32), .DEPTH(24), .ZERO_REG(0)) u1 (
    .clk(clk), .reset_n(reset_n), .wen(u1_wen), .waddr(u1_waddr), .wdata(u1_wdata),
    .raddr(u1_raddr), .rdata(u1_rdata));

  regfile_zero_multiport #(.NREAD(2), .NWRITE(1), .WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u2 (
    .clk(clk), .reset_n(reset_n), .wen(u2_wen), .waddr(u2_waddr), .wdata(u2_wdata),
    .raddr(u2_raddr), .rdata(u2_rdata));

  // Reference read: zero/out-of-range rules, optional write-through, reset forcing 0.
  function automatic regfile_word_t exp_rd(int d, logic [4:0] a);
    regfile_word_t v;
    if ((int'(a) >= DEP[d]) || ((ZR[d] != 0) && (a == 5'd0))) return '0;
    v = mdl[d][a];
    if (BYP) begin
      for (int j = 0; j < NW[d]; j++)
        if (wen_a[d][j] && (waddr_a[d][j] == a)) v = wdata_a[d][j];
    end
    if (!reset_n) v = '0;
    return v;
  endfunction

  task automatic idle();
    for (int d = 0; d < ND; d++) begin
      for (int j = 0; j < 2; j++) begin
        wen_a[d][j] = 1'b0;
        waddr_a[d][j] = '0;
        wdata_a[d][j] = '0;
      end
      for (int i = 0; i < 3; i++) raddr_a[d][i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 3; i++) raddr_a[d][i] = 5'(5 + i);
    #3;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR[d]; i++) begin
        checks++;
        if (rd_a[d][i] !== 32'h0) begin
          failures++;
          $display("FAIL reset_state dut%0d port%0d got=%h exp=0", d, i, rd_a[d][i]);
        end
      end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    wen_a[0][0] = 1'b1; waddr_a[0][0] = 5'd5; wdata_a[0][0] = 32'hdeadbeef;
    tick();
    wen_a[0][0] = 1'b0; raddr_a[0][0] = 5'd5;
    #1;
    checks++;
    if (rd_a[0][0] !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL pre_reset_r5 got=%h exp=deadbeef", rd_a[0][0]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rd_a[0][0] !== 32'h0) begin
      failures++;
      $display("FAIL async_clear got=%h exp=0", rd_a[0][0]);
    end
    wen_a[0][0] = 1'b1;
    tick();
    checks++;
    if (rd_a[0][0] !== 32'h0) begin
      failures++;
      $display("FAIL write_blocked_in_reset got=%h exp=0", rd_a[0][0]);
    end
    wen_a[0][0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (rd_a[0][0] !== 32'h0) begin
      failures++;
      $display("FAIL r5_after_reset got=%h exp=0", rd_a[0][0]);
    end
    tick();
  endtask

  task automatic test_basic();
    idle();
    for (int d = 0; d < ND; d += 2) begin
      wen_a[d][0] = 1'b1; waddr_a[d][0] = 5'd3; wdata_a[d][0] = 32'hd;
      raddr_a[d][0] = 5'd3; raddr_a[d][1] = 5'd3;
    end
    #1;
    for (int d = 0; d < ND; d += 2)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_a[d][i] !== (BYP ? 32'hd : 32'h0)) begin
          failures++;
          $display("FAIL basic_same_cycle dut%0d port%0d got=%h exp=%h", d, i, rd_a[d][i], BYP ? 32'hd : 32'h0);
        end
      end
    tick();
    for (int d = 0; d < ND; d += 2) wen_a[d][0] = 1'b0;
    #1;
    for (int d = 0; d < ND; d += 2)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_a[d][i] !== 32'hd) begin
          failures++;
          $display("FAIL basic_next_cycle dut%0d port%0d got=%h exp=d", d, i, rd_a[d][i]);
        end
      end
    tick();
  endtask

  task automatic test_zero();
    idle();
    wen_a[0][0] = 1'b1; waddr_a[0][0] = 5'd0; wdata_a[0][0] = 32'hffffffff;
    wen_a[1][0] = 1'b1; waddr_a[1][0] = 5'd0; wdata_a[1][0] = 32'hffffffff;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_a[0][i] !== 32'h0) begin
        failures++;
        $display("FAIL zero_same_cycle port%0d got=%h exp=0", i, rd_a[0][i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_a[1][i] !== (BYP ? 32'hffffffff : 32'h0)) begin
        failures++;
        $display("FAIL nozero_same_cycle port%0d got=%h exp=%h", i, rd_a[1][i], BYP ? 32'hffffffff : 32'h0);
      end
    end
    tick();
    wen_a[0][0] = 1'b0; wen_a[1][0] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_a[0][i] !== 32'h0) begin
        failures++;
        $display("FAIL zero_next_cycle port%0d got=%h exp=0", i, rd_a[0][i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_a[1][i] !== 32'hffffffff) begin
        failures++;
        $display("FAIL nozero_next_cycle port%0d got=%h exp=ffffffff", i, rd_a[1][i]);
      end
    end
    tick();
  endtask

  task automatic test_conflict();
    idle();
    wen_a[0][0] = 1'b1; waddr_a[0][0] = 5'd7; wdata_a[0][0] = 32'ha;
    wen_a[0][1] = 1'b1; waddr_a[0][1] = 5'd7; wdata_a[0][1] = 32'hb;
    raddr_a[0][0] = 5'd7; raddr_a[0][1] = 5'd8;
    #1;
    checks++;
    if (rd_a[0][0] !== (BYP ? 32'hb : 32'h0)) begin
      failures++;
      $display("FAIL conflict_same_cycle got=%h exp=%h", rd_a[0][0], BYP ? 32'hb : 32'h0);
    end
    tick();
    waddr_a[0][0] = 5'd8; wdata_a[0][0] = 32'hc;
    wen_a[0][1] = 1'b0; waddr_a[0][1] = 5'd8; wdata_a[0][1] = 32'hee;
    #1;
    checks++;
    if (rd_a[0][0] !== 32'hb) begin
      failures++;
      $display("FAIL conflict_r7 got=%h exp=b", rd_a[0][0]);
    end
    checks++;
    if (rd_a[0][1] !== (BYP ? 32'hc : 32'h0)) begin
      failures++;
      $display("FAIL single_r8_same_cycle got=%h exp=%h", rd_a[0][1], BYP ? 32'hc : 32'h0);
    end
    tick();
    wen_a[0][0] = 1'b0;
    #1;
    checks++;
    if (rd_a[0][1] !== 32'hc) begin
      failures++;
      $display("FAIL single_r8 got=%h exp=c", rd_a[0][1]);
    end
    tick();
  endtask

  task automatic test_range();
    regfile_word_t exp;
    idle();
    wen_a[1][0] = 1'b1; waddr_a[1][0] = 5'd23; wdata_a[1][0] = 32'h23;
    wen_a[1][1] = 1'b1; waddr_a[1][1] = 5'd30; wdata_a[1][1] = 32'h55;
    raddr_a[1][0] = 5'd30;
    #1;
    checks++;
    if (rd_a[1][0] !== 32'h0) begin
      failures++;
      $display("FAIL range_same_cycle got=%h exp=0", rd_a[1][0]);
    end
    tick();
    wen_a[1][0] = 1'b0; wen_a[1][1] = 1'b0;
    #1;
    checks++;
    if (rd_a[1][0] !== 32'h0) begin
      failures++;
      $display("FAIL range_addr30 got=%h exp=0", rd_a[1][0]);
    end
    for (int a = 0; a < 24; a++) begin
      raddr_a[1][0] = 5'(a);
      #1;
      exp = (a == 0) ? 32'hffffffff : ((a == 23) ? 32'h23 : 32'h0);
      checks++;
      if (rd_a[1][0] !== exp) begin
        failures++;
        $display("FAIL range_intact addr%0d got=%h exp=%h", a, rd_a[1][0], exp);
      end
    end
    tick();
  endtask

  task automatic test_random();
    regfile_word_t exp;
    idle();
    #1 reset_n = 1'b0;
    for (int d = 0; d < ND; d++)
      for (int a = 0; a < 32; a++) mdl[d][a] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int c = 0; c < 200; c++) begin
      for (int d = 0; d < ND; d++) begin
        for (int j = 0; j < NW[d]; j++) begin
          wen_a[d][j]   = 1'($urandom_range(0, 1));
          waddr_a[d][j] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
          wdata_a[d][j] = $urandom;
        end
        for (int i = 0; i < NR[d]; i++) raddr_a[d][i] = 5'($urandom_range(0, 31));
      end
      #2;
      for (int d = 0; d < ND; d++)
        for (int i = 0; i < NR[d]; i++) begin
          exp = exp_rd(d, raddr_a[d][i]);
          checks++;
          if (rd_a[d][i] !== exp) begin
            failures++;
            $display("FAIL random cyc%0d dut%0d port%0d addr%0d got=%h exp=%h", c, d, i, raddr_a[d][i], rd_a[d][i], exp);
          end
        end
      @(posedge clk);
      for (int d = 0; d < ND; d++)
        for (int j = 0; j < NW[d]; j++)
          if (wen_a[d][j] && (int'(waddr_a[d][j]) < DEP[d]) && !((ZR[d] != 0) && (waddr_a[d][j] == 5'd0)))
            mdl[d][waddr_a[d][j]] = wdata_a[d][j];
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_conflict();
    test_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
